// File: rtl/ahb_resp_mux.sv
// AHB-Lite response multiplexer: registers the decoder's slave selects during
// the address phase and steers the selected slave's HRDATA/HREADY/HRESP back to
// the master in the data phase. Unmapped NONSEQ/SEQ transfers are answered by a
// built-in default slave with the two-cycle ERROR response.
module ahb_resp_mux #(
    parameter int unsigned                DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0]      DEFAULT_RDATA = '0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL_G,
    input  logic                  HSEL_T,
    input  logic                  HSEL_R,
    input  logic [1:0]            HTRANS,
    input  logic [DATA_WIDTH-1:0] HRDATA_G,
    input  logic [DATA_WIDTH-1:0] HRDATA_T,
    input  logic [DATA_WIDTH-1:0] HRDATA_R,
    input  logic                  HREADYOUT_G,
    input  logic                  HREADYOUT_T,
    input  logic                  HREADYOUT_R,
    input  logic                  HRESP_G,
    input  logic                  HRESP_T,
    input  logic                  HRESP_R,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADY,
    output logic                  HRESP
);

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_G,
        SEL_T,
        SEL_R,
        SEL_DEF
    } dsel_t;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_t;

    dsel_t addr_sel;
    dsel_t dsel;
    ds_t   ds_state;
    ds_t   ds_next;
    logic  def_ready;
    logic  def_resp;

    // Address-phase decode of the selects; G > T > R when more than one is high.
    always_comb begin
        addr_sel = SEL_NONE;
        if (HSEL_G) begin
            addr_sel = SEL_G;
        end else if (HSEL_T) begin
            addr_sel = SEL_T;
        end else if (HSEL_R) begin
            addr_sel = SEL_R;
        end else if (HTRANS[1]) begin
            addr_sel = SEL_DEF;
        end
    end

    // Data-phase owner register; holds while the current data phase is stalled.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel <= SEL_NONE;
        end else if (HREADY) begin
            dsel <= addr_sel;
        end
    end

    // Default-slave state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ds_state <= DS_IDLE;
        end else begin
            ds_state <= ds_next;
        end
    end

    // Default-slave next state: ERR1 always advances, ERR2 re-enters ERR1 on a
    // back-to-back unmapped capture.
    always_comb begin
        ds_next = ds_state;
        case (ds_state)
            DS_IDLE: begin
                if (HREADY && (addr_sel == SEL_DEF)) begin
                    ds_next = DS_ERR1;
                end
            end
            DS_ERR1: begin
                ds_next = DS_ERR2;
            end
            DS_ERR2: begin
                if (HREADY && (addr_sel == SEL_DEF)) begin
                    ds_next = DS_ERR1;
                end else begin
                    ds_next = DS_IDLE;
                end
            end
            default: begin
                ds_next = DS_IDLE;
            end
        endcase
    end

    // Default-slave response outputs, decoded from state only so they never
    // depend on HREADY (which they feed).
    always_comb begin
        def_ready = 1'b1;
        def_resp  = 1'b0;
        case (ds_state)
            DS_ERR1: begin
                def_ready = 1'b0;
                def_resp  = 1'b1;
            end
            DS_ERR2: begin
                def_ready = 1'b1;
                def_resp  = 1'b1;
            end
            default: begin
                def_ready = 1'b1;
                def_resp  = 1'b0;
            end
        endcase
    end

    // Data-phase response mux driven by the registered owner.
    always_comb begin
        HRDATA = DEFAULT_RDATA;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        case (dsel)
            SEL_G: begin
                HRDATA = HRDATA_G;
                HREADY = HREADYOUT_G;
                HRESP  = HRESP_G;
            end
            SEL_T: begin
                HRDATA = HRDATA_T;
                HREADY = HREADYOUT_T;
                HRESP  = HRESP_T;
            end
            SEL_R: begin
                HRDATA = HRDATA_R;
                HREADY = HREADYOUT_R;
                HRESP  = HRESP_R;
            end
            SEL_DEF: begin
                HREADY = def_ready;
                HRESP  = def_resp;
            end
            default: begin
                HRDATA = DEFAULT_RDATA;
                HREADY = 1'b1;
                HRESP  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Self-checking bench for ahb_resp_mux: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model of who owns the data phase.
module tb_ahb_resp_mux;

    localparam logic [31:0] DEF_RD = 32'h0000_0000;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL_G, HSEL_T, HSEL_R;
    logic [1:0]  HTRANS;
    logic [31:0] HRDATA_G, HRDATA_T, HRDATA_R;
    logic        HREADYOUT_G, HREADYOUT_T, HREADYOUT_R;
    logic        HRESP_G, HRESP_T, HRESP_R;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    ahb_resp_mux #(
        .DATA_WIDTH    (32),
        .DEFAULT_RDATA (DEF_RD)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HSEL_G      (HSEL_G),
        .HSEL_T      (HSEL_T),
        .HSEL_R      (HSEL_R),
        .HTRANS      (HTRANS),
        .HRDATA_G    (HRDATA_G),
        .HRDATA_T    (HRDATA_T),
        .HRDATA_R    (HRDATA_R),
        .HREADYOUT_G (HREADYOUT_G),
        .HREADYOUT_T (HREADYOUT_T),
        .HREADYOUT_R (HREADYOUT_R),
        .HRESP_G     (HRESP_G),
        .HRESP_T     (HRESP_T),
        .HRESP_R     (HRESP_R),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Model: owner 0=nobody, 1=G, 2=T, 3=R, 4=default slave.
    // err_cycle counts data-phase cycles spent in the current ERROR response.
    int owner     = 0;
    int err_cycle = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, got, exp, $time);
    endtask

    function automatic int decode();
        if (HSEL_G) return 1;
        if (HSEL_T) return 2;
        if (HSEL_R) return 3;
        if (HTRANS[1]) return 4;
        return 0;
    endfunction

    function automatic logic m_ready();
        logic [3:1] rdy;
        rdy = {HREADYOUT_R, HREADYOUT_T, HREADYOUT_G};
        if (owner == 0) return 1'b1;
        if (owner == 4) return (err_cycle == 1);
        return rdy[owner];
    endfunction

    function automatic logic m_resp();
        logic [3:1] rsp;
        rsp = {HRESP_R, HRESP_T, HRESP_G};
        if (owner == 0) return 1'b0;
        if (owner == 4) return 1'b1;
        return rsp[owner];
    endfunction

    function automatic logic [31:0] m_data();
        case (owner)
            1: return HRDATA_G;
            2: return HRDATA_T;
            3: return HRDATA_R;
            default: return DEF_RD;
        endcase
    endfunction

    // Model advance on each clock edge (inputs are stable there).
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner     = 0;
            err_cycle = 0;
        end else begin
            if (m_ready()) begin
                owner     = decode();
                err_cycle = 0;
            end else if (owner == 4) begin
                err_cycle = err_cycle + 1;
            end
        end
    end

    // Per-cycle comparison, mid-cycle.
    always @(negedge HCLK) begin
        if (chk_en) begin
            if (!HRESETn) begin
                chk("rst_hready", {31'b0, HREADY}, 32'd1);
                chk("rst_hresp",  {31'b0, HRESP},  32'd0);
                chk("rst_hrdata", HRDATA, DEF_RD);
            end else begin
                chk("cyc_hready", {31'b0, HREADY}, {31'b0, m_ready()});
                chk("cyc_hresp",  {31'b0, HRESP},  {31'b0, m_resp()});
                chk("cyc_hrdata", HRDATA, m_data());
            end
        end
    end

    task automatic next();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_bus();
        HSEL_G = 0; HSEL_T = 0; HSEL_R = 0; HTRANS = 2'b00;
        HREADYOUT_G = 1; HREADYOUT_T = 1; HREADYOUT_R = 1;
        HRESP_G = 0; HRESP_T = 0; HRESP_R = 0;
    endtask

    task automatic lit(input string nm, input logic rdy, input logic rsp, input logic [31:0] rd);
        #1;
        chk({nm, "_hready"}, {31'b0, HREADY}, {31'b0, rdy});
        chk({nm, "_hresp"},  {31'b0, HRESP},  {31'b0, rsp});
        chk({nm, "_hrdata"}, HRDATA, rd);
    endtask

    task automatic scen_read_g(input string nm);
        idle_bus();
        HSEL_G = 1; HTRANS = 2'b10;
        next();
        idle_bus();
        HRDATA_G = 32'h1234_5678;
        lit(nm, 1'b1, 1'b0, 32'h1234_5678);
        next();
    endtask

    task automatic randomize_inputs();
        int s;
        s = $urandom_range(0, 9);
        HSEL_G = (s == 1) || (s == 7);
        HSEL_T = (s == 2) || (s == 7) || (s == 8);
        HSEL_R = (s == 3) || (s == 8);
        HTRANS = 2'($urandom_range(0, 3));
        HRDATA_G = $urandom; HRDATA_T = $urandom; HRDATA_R = $urandom;
        HREADYOUT_G = ($urandom_range(0, 3) != 0);
        HREADYOUT_T = ($urandom_range(0, 3) != 0);
        HREADYOUT_R = ($urandom_range(0, 3) != 0);
        HRESP_G = ($urandom_range(0, 7) == 0);
        HRESP_T = ($urandom_range(0, 7) == 0);
        HRESP_R = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        int lowcnt;
        idle_bus();
        HRDATA_G = '0; HRDATA_T = '0; HRDATA_R = '0;
        HRESETn = 1'b0;
        #2;
        lit("reset", 1'b1, 1'b0, DEF_RD);
        chk_en = 1'b1;
        next(); next();
        HRESETn = 1'b1;
        next();

        // 1: zero-wait read from G
        scen_read_g("s1");

        // 2: T stalls 3 cycles; R's address phase is held off until it completes
        idle_bus();
        HSEL_T = 1; HTRANS = 2'b10;
        next();
        HSEL_T = 0; HSEL_R = 1; HTRANS = 2'b10;
        lowcnt = 0;
        for (int i = 0; i < 4; i++) begin
            HREADYOUT_T = (i == 3);
            HRDATA_T = 32'hBEEF_0000 + 32'(i);
            #1;
            if (!HREADY) lowcnt++;
            next();
        end
        chk("s2_wait_cycles", 32'(lowcnt), 32'd3);
        idle_bus();
        HRDATA_R = 32'hCAFE_0002;
        lit("s2_r_owner", 1'b1, 1'b0, 32'hCAFE_0002);
        next();

        // 3: unmapped NONSEQ, then G access during ERR2
        idle_bus();
        HTRANS = 2'b10;
        next();
        idle_bus();
        HRDATA_G = 32'h5555_AAAA;
        lit("s3_err1", 1'b0, 1'b1, DEF_RD);
        next();
        HSEL_G = 1; HTRANS = 2'b10;
        lit("s3_err2", 1'b1, 1'b1, DEF_RD);
        next();
        idle_bus();
        HRDATA_G = 32'h0BAD_F00D;
        lit("s3_g_okay", 1'b1, 1'b0, 32'h0BAD_F00D);
        next();

        // 4: back-to-back unmapped, then IDLE to unmapped
        idle_bus();
        HTRANS = 2'b11;
        next();
        lit("s4_err1a", 1'b0, 1'b1, DEF_RD);
        next();
        lit("s4_err2a", 1'b1, 1'b1, DEF_RD);
        next();
        idle_bus();
        lit("s4_err1b", 1'b0, 1'b1, DEF_RD);
        next();
        lit("s4_err2b", 1'b1, 1'b1, DEF_RD);
        next();
        lit("s4_idle_unmapped", 1'b1, 1'b0, DEF_RD);
        next();
        HTRANS = 2'b01;
        next();
        idle_bus();
        lit("s4_busy_unmapped", 1'b1, 1'b0, DEF_RD);
        next();

        // 5: reset during ERR1 clears outputs with no clock edge
        HTRANS = 2'b10;
        next();
        idle_bus();
        lit("s5_err1", 1'b0, 1'b1, DEF_RD);
        HRESETn = 1'b0;
        lit("s5_async_rst", 1'b1, 1'b0, DEF_RD);
        next(); next();
        HRESETn = 1'b1;
        next();
        scen_read_g("s5_after_rst");

        // Randomized traffic with occasional reset pulses
        for (int c = 0; c < 1500; c++) begin
            randomize_inputs();
            HRESETn = ($urandom_range(0, 99) != 0);
            next();
        end
        HRESETn = 1'b1;
        idle_bus();
        next(); next();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
